// File: rtl/display_pkg.sv
// display_pkg: shared FSM encoding, digit geometry and scan-divider helper for the display scheduler.
package display_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_ITER   = 16;
    localparam int MAX_DEC    = 9999;

    function automatic int scan_div(input int clk_freq, input int refresh_hz);
        return (clk_freq / refresh_hz < 2) ? 2 : clk_freq / refresh_hz;
    endfunction

endpackage

// File: rtl/bin_to_bcd_step.sv
// bin_to_bcd_step: one combinational shift-add-3 iteration over a 20-bit BCD accumulator and 16-bit shifter.
module bin_to_bcd_step (
    input  logic [19:0] bcd_i,
    input  logic [15:0] bin_i,
    output logic [19:0] bcd_o,
    output logic [15:0] bin_o
);

    logic [19:0] adj;

    for (genvar d = 0; d < 5; d++) begin : g_adj
        assign adj[d*4 +: 4] = (bcd_i[d*4 +: 4] >= 4'd5) ? bcd_i[d*4 +: 4] + 4'd3 : bcd_i[d*4 +: 4];
    end

    assign {bcd_o, bin_o} = {adj, bin_i} << 1;

endmodule

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: change-triggered hex/BCD digit loader with atomic commit and anode multiplexing.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits in decimal mode.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int REFRESH_HZ = 25_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        display_is_hex,
    output logic [3:0]  an,
    output logic [3:0]  digit_val,
    output logic        digit_dash,
    output logic        digit_blank,
    output logic        overflow,
    output logic        busy,
    output logic        conv_done
);

    localparam int SCAN_DIV = scan_div(CLK_FREQ, REFRESH_HZ);
    localparam int CW       = $clog2(SCAN_DIV);

    state_t                      state_q;
    logic                        hex_sh_q;
    logic [15:0]                 val_sh_q;
    logic                        pending_q;
    logic [19:0]                 bcd_q, bcd_d;
    logic [15:0]                 bin_q, bin_d;
    logic [3:0]                  iter_q;
    logic [4*NUM_DIGITS-1:0]     disp_q;
    logic                        ovf_q;
    logic                        done_q;
    logic [CW-1:0]               cnt_q;
    logic [1:0]                  sel_q;
    logic [3:0]                  an_q;
    logic [3:0]                  val_q;
    logic                        dash_q;
    logic                        blank_q;
    logic                        blank_d;
    logic                        changed;

    assign changed = {display_is_hex, value} != {hex_sh_q, val_sh_q};

    bin_to_bcd_step u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (bcd_d),
        .bin_o (bin_d)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic disp_hex_q;
    // Blank a digit only when it and every more significant digit is zero; digit 0 always lit.
    assign blank_d = !disp_hex_q && !ovf_q && sel_q != 2'd0 && (disp_q >> {sel_q, 2'b00}) == '0;
`else
    assign blank_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hex_sh_q  <= 1'b1;
            val_sh_q  <= '0;
            pending_q <= 1'b0;
            bcd_q     <= '0;
            bin_q     <= '0;
            iter_q    <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            disp_hex_q <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pending_q <= 1'b0;
                    if (changed) begin
                        hex_sh_q <= display_is_hex;
                        val_sh_q <= value;
                        bin_q    <= value;
                        bcd_q    <= '0;
                        iter_q   <= '0;
                        state_q  <= display_is_hex ? S_COMMIT : S_CONV;
                    end
                end
                S_CONV: begin
                    pending_q <= pending_q | changed;
                    bcd_q     <= bcd_d;
                    bin_q     <= bin_d;
                    iter_q    <= iter_q + 4'd1;
                    if (iter_q == 4'(BCD_ITER - 1)) state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    pending_q <= pending_q | changed;
                    disp_q    <= hex_sh_q ? val_sh_q : bcd_q[15:0];
                    ovf_q     <= !hex_sh_q && val_sh_q > 16'(MAX_DEC);
                    done_q    <= 1'b1;
                    state_q   <= S_IDLE;
`ifdef LEADING_ZERO_BLANK_EN
                    disp_hex_q <= hex_sh_q;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-digit outputs load together on each wrap, so they always describe the same anode.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            an_q    <= 4'hF;
            val_q   <= '0;
            dash_q  <= 1'b0;
            blank_q <= 1'b0;
        end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_q   <= '0;
            sel_q   <= sel_q + 2'd1;
            an_q    <= ~(4'b0001 << sel_q);
            val_q   <= disp_q[{sel_q, 2'b00} +: 4];
            dash_q  <= ovf_q;
            blank_q <= blank_d;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign an          = an_q;
    assign digit_val   = val_q;
    assign digit_dash  = dash_q;
    assign digit_blank = blank_q;
    assign overflow    = ovf_q;
    assign busy        = state_q != S_IDLE;
    assign conv_done   = done_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler: directed checks of reset, scan timing, hex/decimal commits, overflow and aborts.
module tb_display_scan_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        display_is_hex = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  an, digit_val;
    logic        digit_dash, digit_blank, overflow, busy, conv_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_at;
    int          pulses;
    logic        busy_first;
    logic [3:0]  got_val [4];
    logic        got_dash [4];
    logic        got_blank [4];
    logic        seen [4];

    display_scan_scheduler #(.CLK_FREQ(200), .REFRESH_HZ(50)) dut (
        .clk            (clk),
        .reset          (reset),
        .value          (value),
        .display_is_hex (display_is_hex),
        .an             (an),
        .digit_val      (digit_val),
        .digit_dash     (digit_dash),
        .digit_blank    (digit_blank),
        .overflow       (overflow),
        .busy           (busy),
        .conv_done      (conv_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        done_at = 0;
        for (int c = 1; c <= budget && done_at == 0; c++) begin
            @(negedge clk);
            if (c == 1) busy_first = busy;
            if (conv_done) done_at = c;
        end
    endtask

    task automatic scan_capture();
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (an == ~(4'b0001 << i)) begin
                    seen[i]      = 1'b1;
                    got_val[i]   = digit_val;
                    got_dash[i]  = digit_dash;
                    got_blank[i] = digit_blank;
                end
            end
        end
    endtask

    task automatic check_digits(input string tag, input logic [15:0] exp_val, input logic exp_dash,
                                input logic [3:0] exp_blank, input logic chk_val);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s seen%0d", tag, i), 32'(seen[i]), 32'd1);
            if (chk_val) check($sformatf("%s val%0d", tag, i), 32'(got_val[i]), 32'(exp_val[i*4 +: 4]));
            check($sformatf("%s dash%0d", tag, i), 32'(got_dash[i]), 32'(exp_dash));
            check($sformatf("%s blank%0d", tag, i), 32'(got_blank[i]), 32'(exp_blank[i]));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst an", 32'(an), 32'hF);
        check("rst busy", 32'(busy), 32'd0);
        check("rst val", 32'(digit_val), 32'd0);
        check("rst dash", 32'(digit_dash), 32'd0);
        check("rst blank", 32'(digit_blank), 32'd0);
        check("rst ovf", 32'(overflow), 32'd0);
        check("rst done", 32'(conv_done), 32'd0);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("an before wrap", 32'(an), 32'hF);
        check("idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("an first wrap", 32'(an), 32'hE);

        display_is_hex = 1'b1;
        value = 16'hDEAD;
        wait_done(10);
        check("hex latency", 32'(done_at), 32'd2);
        check("hex busy", 32'(busy_first), 32'd1);
        check("hex ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        check("hex pulse", 32'(conv_done), 32'd0);
        scan_capture();
        check_digits("hex", 16'hDEAD, 1'b0, 4'b0000, 1'b1);

        display_is_hex = 1'b0;
        value = 16'd1234;
        wait_done(30);
        check("dec latency", 32'(done_at), 32'd18);
        check("dec busy first", 32'(busy_first), 32'd1);
        check("dec busy end", 32'(busy), 32'd0);
        check("dec ovf", 32'(overflow), 32'd0);
        scan_capture();
        check_digits("dec", 16'h1234, 1'b0, 4'b0000, 1'b1);

        value = 16'hFFFF;
        wait_done(30);
        check("ovf latency", 32'(done_at), 32'd18);
        check("ovf flag", 32'(overflow), 32'd1);
        scan_capture();
        check_digits("ovf", 16'h0000, 1'b1, 4'b0000, 1'b0);

        value = 16'd1234;
        repeat (5) @(negedge clk);
        value = 16'd42;
        wait_done(30);
        check("chg first latency", 32'(done_at), 32'd13);
        check("chg first ovf", 32'(overflow), 32'd0);
        scan_capture();
        check_digits("chg first", 16'h1234, 1'b0, 4'b0000, 1'b1);
        wait_done(30);
        check("chg second latency", 32'(done_at), 32'd2);
`ifdef LEADING_ZERO_BLANK_EN
        scan_capture();
        check_digits("chg second", 16'h0042, 1'b0, 4'b1100, 1'b1);
`else
        scan_capture();
        check_digits("chg second", 16'h0042, 1'b0, 4'b0000, 1'b1);
`endif

        value = 16'd777;
        repeat (6) @(negedge clk);
        check("abort busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort an", 32'(an), 32'hF);
        check("abort busy", 32'(busy), 32'd0);
        check("abort val", 32'(digit_val), 32'd0);
        check("abort ovf", 32'(overflow), 32'd0);
        display_is_hex = 1'b1;
        value = 16'h0000;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (conv_done) pulses++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (conv_done) pulses++;
        end
        check("abort no commit", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
